// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, load-use and branch stall/flush, multiply/divide hold FSM.
// The multiply/divide FSM is only built when MULDIV_EN is defined.
module hazard_unit #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A1_E,
    input  logic [4:0] A2_E,
    input  logic [4:0] A3_E,
    input  logic [4:0] A3_M,
    input  logic [4:0] A3_W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic       MulStartE,
    input  logic       DivStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MulDivBusy,
    output logic       MulDivDoneE
);

    logic lw_stall;
    logic md_stall;

    // Memory-stage result is newer than Writeback, so it wins when both match.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (A3_M != '0) && (A3_M == A1_E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (A3_W != '0) && (A3_W == A1_E))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && (A3_M != '0) && (A3_M == A2_E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (A3_W != '0) && (A3_W == A2_E))
            ForwardBE = 2'b01;
    end

    always_comb begin
        lw_stall = MemReadE && (A3_E != '0) && ((A3_E == A1_D) || (A3_E == A2_D));
    end

`ifdef MULDIV_EN
    localparam int unsigned MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW    = ($clog2(MAX_N) < 5) ? 5 : $clog2(MAX_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MulStartE) begin
                    cnt_d   = CW'(MUL_CYCLES - 2);
                    state_d = (MUL_CYCLES == 2) ? DONE : BUSY;
                end else if (DivStartE) begin
                    cnt_d   = CW'(DIV_CYCLES - 2);
                    state_d = (DIV_CYCLES == 2) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1))
                    state_d = DONE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate with reset so an abandoned op cannot stall through the IDLE-with-start path.
    always_comb begin
        md_stall    = !reset && (((state_q == IDLE) && (MulStartE || DivStartE)) || (state_q == BUSY));
        MulDivBusy  = (state_q != IDLE);
        MulDivDoneE = (state_q == DONE);
    end
`else
    logic unused_md;

    always_comb begin
        md_stall    = 1'b0;
        MulDivBusy  = 1'b0;
        MulDivDoneE = 1'b0;
        unused_md   = ^{clk, reset, MulStartE, DivStartE, MUL_CYCLES[0], DIV_CYCLES[0]};
    end
`endif

    always_comb begin
        StallF = lw_stall || md_stall;
        StallD = lw_stall || md_stall;
        StallE = md_stall;
        FlushM = md_stall;
        FlushD = PCSrcE;
        FlushE = (lw_stall || PCSrcE) && !md_stall;
    end

endmodule
